// File: rtl/boot_select_ctrl.sv
// Boot-source selector for the badge bootloader: debounces buttons, latches a flash source,
// pulses the flash-mux clock on a change and finally drops PROGRAMN to reload the FPGA.
module boot_select_ctrl #(
  parameter int NUM_BTN        = 8,
  parameter int NUM_SRC        = 2,
  parameter int TICK_DIV       = 256,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int PULSE_START    = 31,
  parameter int PULSE_END      = 127,
  parameter int SWITCH_TICKS   = 1,
  parameter int STAY_BTN       = 2,
  parameter int HOLD_BTN       = 2,
  parameter int TIMEOUT_TICKS  = 0,
  localparam int SRC_W         = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               usb_vdet,
  input  logic               boot_req,
  output logic [SRC_W-1:0]   fsel_d,
  output logic               fsel_c,
  output logic               programn,
  output logic [2:0]         state,
  output logic [1:0]         boot_cause
);

  localparam int PS_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX = (DEBOUNCE_TICKS > SWITCH_TICKS) ? DEBOUNCE_TICKS : SWITCH_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int TO_W   = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0] PS_ONE    = PS_W'(1);
  localparam logic [PS_W-1:0] P_START   = PS_W'(PULSE_START);
  localparam logic [PS_W-1:0] P_END     = PS_W'(PULSE_END);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0] INIT_LAST = PH_W'(DEBOUNCE_TICKS);
  localparam logic [PH_W-1:0] SW_LAST   = PH_W'(SWITCH_TICKS - 1);
  localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0] DB_NEED   = DB_W'(DEBOUNCE_TICKS);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_TICKS);
  localparam bit              TO_EN     = (TIMEOUT_TICKS != 0);

  localparam logic [1:0] CAUSE_NO_VBUS = 2'd0;
  localparam logic [1:0] CAUSE_NO_STAY = 2'd1;
  localparam logic [1:0] CAUSE_REQ     = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_SAMPLE    = 3'd1,
    ST_SWITCH    = 3'd2,
    ST_WAIT_BOOT = 3'd3,
    ST_DOBOOT    = 3'd4
  } state_t;

  logic [PS_W-1:0]    pre_cnt_r;
  logic [PS_W-1:0]    pre_nxt_s;
  logic               tick_s;
  logic [NUM_BTN-1:0] btn_meta_r;
  logic [NUM_BTN-1:0] btn_sync_r;
  logic               usb_meta_r;
  logic               usb_sync_r;
  logic [NUM_BTN-1:0] db_cand_r;
  logic [NUM_BTN-1:0] btn_db_r;
  logic [NUM_BTN-1:0] db_accept_s;
  logic [DB_W-1:0]    db_cnt_r     [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_nxt_s [NUM_BTN];
  state_t             state_r;
  logic [PH_W-1:0]    ph_r;
  logic [TO_W-1:0]    to_cnt_r;
  logic [TO_W-1:0]    to_inc_s;
  logic [SRC_W-1:0]   src_s;
  logic [SRC_W-1:0]   fsel_d_r;
  logic               fsel_c_r;
  logic               programn_r;
  logic               stay_r;
  logic               boot_seen_r;
  logic [1:0]         cause_r;
  logic               hold_s;
  logic               window_s;
  logic               pulse_s;

  // Prescaler next value and tick strobe
  always_comb begin
    tick_s = (pre_cnt_r == PS_LAST);
    if (tick_s) begin
      pre_nxt_s = '0;
    end else begin
      pre_nxt_s = pre_cnt_r + PS_ONE;
    end
  end

  // Prescaler and two-flop synchronisers for the asynchronous pins
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_r  <= '0;
      btn_meta_r <= '1;
      btn_sync_r <= '1;
      usb_meta_r <= 1'b0;
      usb_sync_r <= 1'b0;
    end else begin
      pre_cnt_r  <= pre_nxt_s;
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
      usb_meta_r <= usb_vdet;
      usb_sync_r <= usb_meta_r;
    end
  end

  // Per-button run length of identical tick samples, saturating at the acceptance count
  always_comb begin
    db_accept_s = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_nxt_s[i] = db_cnt_r[i];
      if (btn_sync_r[i] != db_cand_r[i]) begin
        db_cnt_nxt_s[i] = DB_ONE;
      end else if (db_cnt_r[i] != DB_NEED) begin
        db_cnt_nxt_s[i] = db_cnt_r[i] + DB_ONE;
      end else begin
        db_cnt_nxt_s[i] = db_cnt_r[i];
      end
      db_accept_s[i] = (db_cnt_nxt_s[i] == DB_NEED);
    end
  end

  // Debounce registers; levels stay active-low like the pins
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cand_r <= '1;
      btn_db_r  <= '1;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else if (tick_s) begin
      db_cand_r <= btn_sync_r;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_r[i] <= db_cnt_nxt_s[i];
        btn_db_r[i] <= db_accept_s[i] ? btn_sync_r[i] : btn_db_r[i];
      end
    end
  end

  // Source choice, hold request and saturating timeout increment
  always_comb begin
    src_s = '0;
    for (int i = NUM_SRC - 1; i >= 1; i--) begin
      src_s = !btn_db_r[i] ? SRC_W'(i) : src_s;
    end
    hold_s = !btn_db_r[HOLD_BTN];
    if (TO_EN && (to_cnt_r != TO_LIMIT)) begin
      to_inc_s = to_cnt_r + TO_ONE;
    end else begin
      to_inc_s = to_cnt_r;
    end
  end

  // Mux-clock pulse, looked up one cycle early so the registered output lines up with the count
  always_comb begin
    window_s = (pre_nxt_s >= P_START) && (pre_nxt_s < P_END);
    pulse_s  = 1'b0;
    if ((state_r == ST_SWITCH) && (ph_r == '0) && !tick_s) begin
      pulse_s = window_s;
    end else if ((state_r == ST_SAMPLE) && tick_s && (src_s != '0)) begin
      pulse_s = window_s;
    end else begin
      pulse_s = 1'b0;
    end
  end

  // Boot-sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      ph_r        <= '0;
      to_cnt_r    <= '0;
      fsel_d_r    <= '0;
      fsel_c_r    <= 1'b0;
      programn_r  <= 1'b1;
      stay_r      <= 1'b0;
      boot_seen_r <= 1'b0;
      cause_r     <= CAUSE_NO_VBUS;
    end else begin
      fsel_c_r <= pulse_s;
      if (boot_req) begin
        boot_seen_r <= 1'b1;
      end
      if (tick_s) begin
        case (state_r)
          ST_INIT: begin
            if (ph_r == INIT_LAST) begin
              ph_r    <= '0;
              state_r <= ST_SAMPLE;
            end else begin
              ph_r <= ph_r + PH_ONE;
            end
          end
          ST_SAMPLE: begin
            fsel_d_r <= src_s;
            stay_r   <= !btn_db_r[STAY_BTN];
            ph_r     <= '0;
            state_r  <= (src_s != '0) ? ST_SWITCH : ST_WAIT_BOOT;
          end
          ST_SWITCH: begin
            if (ph_r == SW_LAST) begin
              ph_r    <= '0;
              state_r <= ST_WAIT_BOOT;
            end else begin
              ph_r <= ph_r + PH_ONE;
            end
          end
          ST_WAIT_BOOT: begin
            // A held button freezes both the decision and the timeout count
            if (!hold_s) begin
              to_cnt_r <= to_inc_s;
              if (!usb_sync_r) begin
                cause_r <= CAUSE_NO_VBUS;
                state_r <= ST_DOBOOT;
              end else if (!stay_r) begin
                cause_r <= CAUSE_NO_STAY;
                state_r <= ST_DOBOOT;
              end else if (boot_seen_r) begin
                cause_r <= CAUSE_REQ;
                state_r <= ST_DOBOOT;
              end else if (TO_EN && (to_inc_s == TO_LIMIT)) begin
                cause_r <= CAUSE_TIMEOUT;
                state_r <= ST_DOBOOT;
              end
            end
          end
          ST_DOBOOT: begin
            programn_r <= 1'b0;
          end
          default: begin
            state_r <= ST_INIT;
          end
        endcase
      end
    end
  end

  assign fsel_d     = fsel_d_r;
  assign fsel_c     = fsel_c_r;
  assign programn   = programn_r;
  assign state      = state_r;
  assign boot_cause = cause_r;

endmodule
